// File: rtl/text_line_renderer_pkg.sv
// text_pkg: shared types and constants for the text line renderer.
//   state_t     renderer FSM states (IDLE/ARMED/DRAW/DONE)
//   GLYPH_W/H   glyph cell size in pixels
//   CH_*        character codes understood by the glyph ROM
package text_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, DRAW, DONE} state_t;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;

  localparam logic [5:0] CH_BLANK = 6'h00;
  localparam logic [5:0] CH_0     = 6'h1B;
  localparam logic [5:0] CH_1     = 6'h1C;
  localparam logic [5:0] CH_2     = 6'h1D;
  localparam logic [5:0] CH_3     = 6'h1E;
  localparam logic [5:0] CH_4     = 6'h1F;
  localparam logic [5:0] CH_5     = 6'h20;
  localparam logic [5:0] CH_6     = 6'h21;
  localparam logic [5:0] CH_7     = 6'h22;
  localparam logic [5:0] CH_8     = 6'h23;
  localparam logic [5:0] CH_9     = 6'h24;
endpackage

// File: rtl/text_line_renderer_if.sv
// text_line_renderer_if: control bundle between a host and the renderer.
//   wr_en/wr_idx/wr_chr   line buffer write port
//   draw_req/draw_x/y     render request with box origin
//   busy/line_done        render status back to the host
// master = host side, slave = renderer side.
interface text_line_renderer_if #(
  parameter int NCHARS  = 16,
  parameter int COORD_W = 10,
  parameter int CHR_W   = 6
);
  localparam int IDX_W = (NCHARS > 1) ? $clog2(NCHARS) : 1;

  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [CHR_W-1:0]   wr_chr;
  logic               draw_req;
  logic [COORD_W-1:0] draw_x;
  logic [COORD_W-1:0] draw_y;
  logic               busy;
  logic               line_done;

  modport master (output wr_en, wr_idx, wr_chr, draw_req, draw_x, draw_y,
                  input  busy, line_done);
  modport slave  (input  wr_en, wr_idx, wr_chr, draw_req, draw_x, draw_y,
                  output busy, line_done);
endinterface

// File: rtl/text_line_renderer_glyph_rom.sv
// glyph_rom: combinational 8x8 glyph lookup.
//   code  in   character code
//   row   in   glyph row 0..7 (0 = top)
//   bits  out  row pixels, bit 7 = leftmost column
// Digits live at CH_0..CH_9; every other code is blank.
module glyph_rom
  import text_pkg::*;
#(
  parameter int CHR_W = 6
) (
  input  logic [CHR_W-1:0] code,
  input  logic [2:0]       row,
  output logic [7:0]       bits
);
  logic [63:0] g;  // whole glyph, top row in the most significant byte

  always_comb begin
    g = '0;
    case (code)
      CHR_W'(CH_0): g = 64'h7CC6_CEDE_F6E6_7C00;
      CHR_W'(CH_1): g = 64'h3070_3030_3030_FC00;
      CHR_W'(CH_2): g = 64'h78CC_0C38_60CC_FC00;
      CHR_W'(CH_3): g = 64'h78CC_0C38_0CCC_7800;
      CHR_W'(CH_4): g = 64'h1C3C_6CCC_FE0C_1E00;
      CHR_W'(CH_5): g = 64'hFCC0_F80C_0CCC_7800;
      CHR_W'(CH_6): g = 64'h3860_C0F8_CCCC_7800;
      CHR_W'(CH_7): g = 64'hFCCC_0C18_3030_3000;
      CHR_W'(CH_8): g = 64'h78CC_CC78_CCCC_7800;
      CHR_W'(CH_9): g = 64'h78CC_CC7C_0C18_7000;
      default:      g = '0;
    endcase
    // ~row == 7-row for a 3-bit row: row 0 picks the top byte
    bits = g[{~row, 3'b000} +: 8];
  end
endmodule

// File: rtl/text_line_renderer.sv
// text_line_renderer: draws a line of NCHARS 8x8 glyphs at a latched origin
// into the raster stream of the timing generator.
//   pixclk       pixel clock
//   rst          asynchronous active-high reset
//   CounterX/Y   raster position
//   bus          slave side of text_line_renderer_if (buffer writes,
//                draw request/origin, busy, line_done)
//   pix          glyph pixel for the counters sampled on the previous edge
//   pix_in_box   previous-cycle counters fell inside the text box
// Build option: define TEXT_SCALE2_EN to draw every glyph pixel as 2x2.
module text_line_renderer
  import text_pkg::*;
#(
  parameter int NCHARS  = 16,
  parameter int COORD_W = 10,
  parameter int CHR_W   = 6
) (
  input  logic               pixclk,
  input  logic               rst,
  input  logic [COORD_W-1:0] CounterX,
  input  logic [COORD_W-1:0] CounterY,
  text_line_renderer_if.slave bus,
  output logic               pix,
  output logic               pix_in_box
);
  localparam int IDX_W = (NCHARS > 1) ? $clog2(NCHARS) : 1;
  localparam int CW    = COORD_W + 1;  // one extra bit so offsets never wrap
`ifdef TEXT_SCALE2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int BOX_W = NCHARS * GLYPH_W * S;
  localparam int BOX_H = GLYPH_H * S;

  state_t state, state_nxt;
  logic [COORD_W-1:0] ox, oy;
  logic [NCHARS-1:0][CHR_W-1:0] line_buf;

  // ---- FSM ----
  always_ff @(posedge pixclk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.draw_req) state_nxt = ARMED;
      ARMED: if (CounterY == oy) state_nxt = DRAW;
      // second term: box ran off the bottom and the frame wrapped
      DRAW:  if (({1'b0, CounterY} == ({1'b0, oy} + CW'(BOX_H))) || (CounterY < oy))
               state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state == ARMED) || (state == DRAW);
    bus.line_done = (state == DONE);
  end

  always_ff @(posedge pixclk or posedge rst)
    if (rst) begin
      ox <= '0;
      oy <= '0;
    end else if (state == IDLE && bus.draw_req) begin
      ox <= bus.draw_x;
      oy <= bus.draw_y;
    end

  // ---- line buffer: slots outside 0..NCHARS-1 never match, so they drop ----
  always_ff @(posedge pixclk or posedge rst)
    if (rst) line_buf <= '0;
    else
      for (int i = 0; i < NCHARS; i++)
        if (bus.wr_en && bus.wr_idx == IDX_W'(i)) line_buf[i] <= bus.wr_chr;

  // ---- pixel pipeline ----
  logic [CW-1:0]    dx, dy;
  logic             in_box;
  logic [2:0]       col, row;
  logic [IDX_W-1:0] idx;
  logic [7:0]       row_bits;

  always_comb begin
    dx = {1'b0, CounterX} - {1'b0, ox};
    dy = {1'b0, CounterY} - {1'b0, oy};
    // a negative offset shows up as MSB set, which also exceeds the box size
    in_box = !dx[CW-1] && (dx < CW'(BOX_W)) && !dy[CW-1] && (dy < CW'(BOX_H));
`ifdef TEXT_SCALE2_EN
    col = dx[3:1];
    row = dy[3:1];
    idx = IDX_W'(dx >> 4);
`else
    col = dx[2:0];
    row = dy[2:0];
    idx = IDX_W'(dx >> 3);
`endif
  end

  glyph_rom #(.CHR_W(CHR_W)) u_rom (
    .code (line_buf[idx]),
    .row  (row),
    .bits (row_bits)
  );

  always_ff @(posedge pixclk or posedge rst)
    if (rst) begin
      pix        <= 1'b0;
      pix_in_box <= 1'b0;
    end else begin
      pix        <= (state == DRAW) && in_box && row_bits[~col];
      pix_in_box <= (state == DRAW) && in_box;
    end
endmodule
